// File: rtl/brq_pkg.sv
// Shared types and helpers for the branch resolution queue.
// Tracks predicted branches in program order between fetch and predictor training.
package brq_pkg;

  localparam int unsigned INSN_BYTES   = 4;
  localparam int unsigned BRQ_PC_WIDTH = 32;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    BLOCK = 1'b1
  } brq_state_t;

  typedef struct packed {
    logic                    valid;
    logic                    resolved;
    logic [BRQ_PC_WIDTH-1:0] pc;
    logic                    pred_taken;
    logic [BRQ_PC_WIDTH-1:0] pred_target;
    logic                    act_taken;
    logic [BRQ_PC_WIDTH-1:0] act_target;
  } brq_entry_t;

  // Age is measured as distance from head, so the compare survives pointer wrap.
  function automatic logic is_younger(input int unsigned tag, input int unsigned ref_tag,
                                      input int unsigned head, input int unsigned depth);
    return ((tag + depth - head) % depth) > ((ref_tag + depth - head) % depth);
  endfunction

endpackage

// File: rtl/branch_resolution_queue_if.sv
// Fetch/execute/predictor-update bundle of the branch resolution queue.
interface branch_resolution_queue_if #(
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned PTR_WIDTH = 3
);
  logic                 alloc_valid;
  logic                 alloc_ready;
  logic [PC_WIDTH-1:0]  alloc_pc;
  logic                 alloc_pred_taken;
  logic [PC_WIDTH-1:0]  alloc_pred_target;
  logic [PTR_WIDTH-1:0] alloc_tag;
  logic                 resolve_valid;
  logic [PTR_WIDTH-1:0] resolve_tag;
  logic                 resolve_taken;
  logic [PC_WIDTH-1:0]  resolve_target;
  logic                 upd_valid;
  logic [PC_WIDTH-1:0]  upd_pc;
  logic                 upd_taken;
  logic [PC_WIDTH-1:0]  upd_target;
  logic                 flush;
  logic [PC_WIDTH-1:0]  recover_pc;
  logic [PTR_WIDTH:0]   count;
  logic                 empty;
  logic                 full;

  modport master (
    output alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target,
           resolve_valid, resolve_tag, resolve_taken, resolve_target,
    input  alloc_ready, alloc_tag, upd_valid, upd_pc, upd_taken, upd_target,
           flush, recover_pc, count, empty, full
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_pred_taken, alloc_pred_target,
           resolve_valid, resolve_tag, resolve_taken, resolve_target,
    output alloc_ready, alloc_tag, upd_valid, upd_pc, upd_taken, upd_target,
           flush, recover_pc, count, empty, full
  );
endinterface

// File: rtl/brq_flush_ctrl.sv
// RUN/BLOCK control: registers the flush pulse and recovery PC, then holds
// allocation off for FLUSH_CYCLES cycles after each mispredict.
module brq_flush_ctrl
  import brq_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = BRQ_PC_WIDTH,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mispredict,
  input  logic                resolve_taken,
  input  logic [PC_WIDTH-1:0] resolve_target,
  input  logic [PC_WIDTH-1:0] branch_pc,
  output brq_state_t          state,
  output logic                flush,
  output logic [PC_WIDTH-1:0] recover_pc
);
  localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] block_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      block_cnt  <= '0;
      flush      <= 1'b0;
      recover_pc <= '0;
    end else begin
      flush <= mispredict;
      if (mispredict) begin
        // a mispredict during BLOCK restarts the blocking window
        state      <= BLOCK;
        block_cnt  <= CNT_W'(FLUSH_CYCLES);
        recover_pc <= resolve_taken ? resolve_target : branch_pc + PC_WIDTH'(INSN_BYTES);
      end else if (state == BLOCK) begin
        if (block_cnt <= CNT_ONE) begin
          state     <= RUN;
          block_cnt <= '0;
        end else begin
          block_cnt <= block_cnt - CNT_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/branch_resolution_queue.sv
// In-order queue of predicted branches: out-of-order resolve by tag, mispredict
// squash/flush, and one predictor/BTB update per branch retired from the head.
module branch_resolution_queue
  import brq_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = BRQ_PC_WIDTH,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned PTR_WIDTH    = 3,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic                      clk,
  input logic                      reset,
  branch_resolution_queue_if.slave bus
);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [PTR_WIDTH:0]   CNT_ONE = 1;

  brq_entry_t           entries [DEPTH];
  brq_entry_t           alloc_e;
  brq_state_t           state;
  logic [PTR_WIDTH-1:0] head, tail, res_age;
  logic [PTR_WIDTH:0]   count_q, count_d, squash_n;
  logic                 full_now, res_hit, mispredict_now, alloc_fire, retire_fire;
  logic                 upd_valid_q, upd_taken_q;
  logic [PC_WIDTH-1:0]  upd_pc_q, upd_target_q;

  assign full_now       = (count_q == (PTR_WIDTH+1)'(DEPTH));
  assign res_hit        = bus.resolve_valid && entries[bus.resolve_tag].valid
                          && !entries[bus.resolve_tag].resolved;
  assign mispredict_now = res_hit &&
                          ((bus.resolve_taken != entries[bus.resolve_tag].pred_taken) ||
                           (bus.resolve_taken &&
                            (bus.resolve_target != PC_WIDTH'(entries[bus.resolve_tag].pred_target))));
  assign alloc_fire     = bus.alloc_valid && bus.alloc_ready;
  assign retire_fire    = entries[head].valid && entries[head].resolved;

  // everything behind the mispredicted entry, measured from the pre-cycle head
  assign res_age  = bus.resolve_tag - head;
  assign squash_n = count_q - {1'b0, res_age} - CNT_ONE;

  always_comb begin
    alloc_e             = '0;
    alloc_e.valid       = 1'b1;
    alloc_e.pc          = BRQ_PC_WIDTH'(bus.alloc_pc);
    alloc_e.pred_taken  = bus.alloc_pred_taken;
    alloc_e.pred_target = BRQ_PC_WIDTH'(bus.alloc_pred_target);
  end

  always_comb begin
    count_d = count_q;
    if (mispredict_now) count_d = count_d - squash_n;
    if (retire_fire)    count_d = count_d - CNT_ONE;
    if (alloc_fire)     count_d = count_d + CNT_ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= '0;
      head         <= '0;
      tail         <= '0;
      count_q      <= '0;
      upd_valid_q  <= 1'b0;
      upd_taken_q  <= 1'b0;
      upd_pc_q     <= '0;
      upd_target_q <= '0;
    end else begin
      if (mispredict_now) begin
        for (int unsigned i = 0; i < DEPTH; i++)
          if (is_younger(i, 32'(bus.resolve_tag), 32'(head), DEPTH)) entries[i].valid <= 1'b0;
        tail <= bus.resolve_tag + PTR_ONE;
      end else if (alloc_fire) begin
        entries[tail] <= alloc_e;
        tail          <= tail + PTR_ONE;
      end
      if (res_hit) begin
        entries[bus.resolve_tag].resolved   <= 1'b1;
        entries[bus.resolve_tag].act_taken  <= bus.resolve_taken;
        entries[bus.resolve_tag].act_target <= BRQ_PC_WIDTH'(bus.resolve_target);
      end
      upd_valid_q <= retire_fire;
      if (retire_fire) begin
        entries[head].valid <= 1'b0;
        head                <= head + PTR_ONE;
        upd_pc_q            <= PC_WIDTH'(entries[head].pc);
        upd_taken_q         <= entries[head].act_taken;
        upd_target_q        <= PC_WIDTH'(entries[head].act_target);
      end
      count_q <= count_d;
    end
  end

  brq_flush_ctrl #(
    .PC_WIDTH     (PC_WIDTH),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) u_flush_ctrl (
    .clk            (clk),
    .reset          (reset),
    .mispredict     (mispredict_now),
    .resolve_taken  (bus.resolve_taken),
    .resolve_target (bus.resolve_target),
    .branch_pc      (PC_WIDTH'(entries[bus.resolve_tag].pc)),
    .state          (state),
    .flush          (bus.flush),
    .recover_pc     (bus.recover_pc)
  );

  assign bus.alloc_ready = (state == RUN) && !full_now && !mispredict_now;
  assign bus.alloc_tag   = tail;
  assign bus.count       = count_q;
  assign bus.empty       = (count_q == '0);
  assign bus.full        = full_now;
  assign bus.upd_valid   = upd_valid_q;
  assign bus.upd_pc      = upd_pc_q;
  assign bus.upd_taken   = upd_taken_q;
  assign bus.upd_target  = upd_target_q;

endmodule

// File: tb/tb_branch_resolution_queue.sv
// Bench for branch_resolution_queue: directed scenarios plus random traffic,
// checked cycle by cycle against a program-order queue model.
module tb_branch_resolution_queue;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned FLUSH = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  branch_resolution_queue_if #(.PC_WIDTH(32), .PTR_WIDTH(3)) bus ();

  branch_resolution_queue #(
    .PC_WIDTH     (32),
    .DEPTH        (DEPTH),
    .PTR_WIDTH    (3),
    .FLUSH_CYCLES (FLUSH)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: in-flight branches in program order, front is the oldest.
  typedef struct {
    int unsigned tag;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
    logic        res;
    logic        at;
    logic [31:0] atgt;
  } ment_t;

  ment_t       mq[$];
  int unsigned m_tail = 0;
  int unsigned m_blk  = 0;
  logic        e_upd_v, e_upd_t, e_flush;
  logic [31:0] e_upd_pc, e_upd_tgt, e_rec;

  task automatic idle_in();
    bus.alloc_valid       = 1'b0;
    bus.alloc_pc          = '0;
    bus.alloc_pred_taken  = 1'b0;
    bus.alloc_pred_target = '0;
    bus.resolve_valid     = 1'b0;
    bus.resolve_tag       = '0;
    bus.resolve_taken     = 1'b0;
    bus.resolve_target    = '0;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic step();
    int    ri = -1;
    bit    hit = 0, mis = 0, rdy, full;
    ment_t e;
    #1;
    full = (mq.size() == DEPTH);
    foreach (mq[i]) if (mq[i].tag == 32'(bus.resolve_tag)) ri = i;
    if (bus.resolve_valid && ri >= 0) begin
      if (!mq[ri].res) begin
        hit = 1;
        mis = (bus.resolve_taken != mq[ri].pt) ||
              (bus.resolve_taken && bus.resolve_target != mq[ri].ptgt);
      end
    end
    rdy = (m_blk == 0) && !full && !mis;
    check_val("alloc_ready", bus.alloc_ready, rdy);
    check_val("alloc_tag", bus.alloc_tag, m_tail);
    check_val("count", bus.count, mq.size());
    check_val("empty", bus.empty, mq.size() == 0);
    check_val("full", bus.full, full);

    e_upd_v = 0;
    if (mq.size() > 0 && mq[0].res) begin
      e_upd_v   = 1;
      e_upd_pc  = mq[0].pc;
      e_upd_t   = mq[0].at;
      e_upd_tgt = mq[0].atgt;
    end
    e_flush = mis;
    if (mis) e_rec = bus.resolve_taken ? bus.resolve_target : mq[ri].pc + 32'd4;
    if (hit) begin
      mq[ri].res  = 1;
      mq[ri].at   = bus.resolve_taken;
      mq[ri].atgt = bus.resolve_target;
    end
    if (mis) begin
      while (mq.size() > ri + 1) void'(mq.pop_back());
      m_tail = (32'(bus.resolve_tag) + 1) % DEPTH;
    end
    if (e_upd_v) void'(mq.pop_front());
    if (bus.alloc_valid && rdy) begin
      e.tag  = m_tail;
      e.pc   = bus.alloc_pc;
      e.pt   = bus.alloc_pred_taken;
      e.ptgt = bus.alloc_pred_target;
      e.res  = 0;
      e.at   = 0;
      e.atgt = '0;
      mq.push_back(e);
      m_tail = (m_tail + 1) % DEPTH;
    end
    m_blk = mis ? FLUSH : ((m_blk > 0) ? m_blk - 1 : 0);

    @(posedge clk);
    #1;
    check_val("upd_valid", bus.upd_valid, e_upd_v);
    if (e_upd_v) begin
      check_val("upd_pc", bus.upd_pc, e_upd_pc);
      check_val("upd_taken", bus.upd_taken, e_upd_t);
      check_val("upd_target", bus.upd_target, e_upd_tgt);
    end
    check_val("flush", bus.flush, e_flush);
    if (e_flush) check_val("recover_pc", bus.recover_pc, e_rec);
    @(negedge clk);
  endtask

  task automatic do_alloc(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    idle_in();
    bus.alloc_valid       = 1'b1;
    bus.alloc_pc          = pc;
    bus.alloc_pred_taken  = pt;
    bus.alloc_pred_target = tgt;
    step();
  endtask

  task automatic set_resolve(input logic [2:0] tag, input logic taken, input logic [31:0] tgt);
    bus.resolve_valid  = 1'b1;
    bus.resolve_tag    = tag;
    bus.resolve_taken  = taken;
    bus.resolve_target = tgt;
  endtask

  task automatic do_resolve(input logic [2:0] tag, input logic taken, input logic [31:0] tgt);
    idle_in();
    set_resolve(tag, taken, tgt);
    step();
  endtask

  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) begin
      idle_in();
      step();
    end
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_tail = 0;
    m_blk  = 0;
    check_val("rst_count", bus.count, 0);
    check_val("rst_empty", bus.empty, 1);
    check_val("rst_full", bus.full, 0);
    check_val("rst_flush", bus.flush, 0);
    check_val("rst_upd_valid", bus.upd_valid, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    idle_in();
    #1;
    do_reset();

    // reset while five entries are live and allocation is blocked
    for (int i = 0; i < 6; i++) do_alloc(32'h1000 + 32'(4 * i), 1'b0, 32'h0);
    do_resolve(3'd4, 1'b1, 32'h900);
    check_val("pre_rst_count", bus.count, 5);
    check_val("pre_rst_blocked", bus.alloc_ready, 0);
    do_reset();
    #1;
    check_val("post_rst_ready", bus.alloc_ready, 1);
    do_idle(1);

    // fill, refused alloc while full, retire and wrap
    do_reset();
    for (int i = 0; i < 8; i++) do_alloc(32'h100 + 32'(4 * i), 1'b0, 32'h0);
    check_val("fill_full", bus.full, 1);
    check_val("fill_ready", bus.alloc_ready, 0);
    idle_in();
    bus.alloc_valid = 1'b1;
    bus.alloc_pc    = 32'h500;
    set_resolve(3'd0, 1'b0, 32'h0);
    step();
    do_idle(1);
    check_val("wrap_upd_pc", bus.upd_pc, 32'h100);
    check_val("wrap_tag", bus.alloc_tag, 0);
    do_alloc(32'h120, 1'b0, 32'h0);
    do_idle(8);

    // out-of-order resolution retires in program order
    do_reset();
    for (int i = 0; i < 3; i++) do_alloc(32'h300 + 32'(4 * i), 1'b0, 32'h0);
    do_resolve(3'd2, 1'b0, 32'h0);
    do_resolve(3'd1, 1'b0, 32'h0);
    check_val("ooo_no_upd", bus.upd_valid, 0);
    do_resolve(3'd0, 1'b0, 32'h0);
    do_idle(1);
    check_val("ooo_first_pc", bus.upd_pc, 32'h300);
    do_idle(3);

    // direction mispredict squashes younger entries
    do_reset();
    do_alloc(32'h1F0, 1'b0, 32'h0);
    do_alloc(32'h200, 1'b1, 32'h300);
    do_alloc(32'h210, 1'b0, 32'h0);
    do_alloc(32'h220, 1'b0, 32'h0);
    do_resolve(3'd1, 1'b0, 32'h0);
    check_val("dir_flush", bus.flush, 1);
    check_val("dir_recover", bus.recover_pc, 32'h204);
    check_val("dir_count", bus.count, 2);
    check_val("dir_tag", bus.alloc_tag, 2);
    do_resolve(3'd3, 1'b1, 32'h999);
    do_idle(4);

    // target mispredict
    do_reset();
    do_alloc(32'h380, 1'b1, 32'h400);
    do_resolve(3'd0, 1'b1, 32'h480);
    check_val("tgt_recover", bus.recover_pc, 32'h480);
    do_idle(1);
    check_val("tgt_upd_target", bus.upd_target, 32'h480);
    do_idle(2);

    // mispredict, alloc request and head retire in one cycle
    do_reset();
    for (int i = 0; i < 3; i++) do_alloc(32'h600 + 32'(4 * i), 1'b0, 32'h0);
    do_resolve(3'd0, 1'b0, 32'h0);
    idle_in();
    bus.alloc_valid = 1'b1;
    bus.alloc_pc    = 32'h6F0;
    set_resolve(3'd1, 1'b1, 32'h700);
    step();
    check_val("sim_upd", bus.upd_valid, 1);
    check_val("sim_flush", bus.flush, 1);
    check_val("sim_count", bus.count, 1);
    do_idle(4);

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      logic        pt;
      logic [31:0] ptgt;
      idle_in();
      if ($urandom_range(0, 299) == 0) do_reset();
      bus.alloc_valid       = ($urandom_range(0, 99) < 60);
      bus.alloc_pc          = $urandom & 32'hFFFF_FFFC;
      bus.alloc_pred_taken  = 1'($urandom_range(0, 1));
      bus.alloc_pred_target = 32'($urandom_range(0, 15)) << 2;
      if (mq.size() > 0 && $urandom_range(0, 99) < 55) begin
        int k;
        k    = int'($urandom_range(0, mq.size() - 1));
        pt   = mq[k].pt;
        ptgt = mq[k].ptgt;
        case ($urandom_range(0, 7))
          0:       set_resolve(3'(mq[k].tag), !pt, $urandom & 32'hFFFF_FFFC);
          1:       set_resolve(3'(mq[k].tag), pt, pt ? ptgt + 32'h8 : 32'h0);
          default: set_resolve(3'(mq[k].tag), pt, pt ? ptgt : ($urandom & 32'hFFFF_FFFC));
        endcase
      end else if ($urandom_range(0, 9) == 0) begin
        set_resolve(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolution_queue.md
Name: branch_resolution_queue

Overview:
- In-order tracker for in-flight predicted branches, placed between fetch and the branch predictor/BTB update ports.
- Fetch allocates one entry per predicted branch and receives a tag. Execute resolves entries by tag, possibly out of order.
- The block detects mispredicts, issues a flush with the recovery PC, and squashes younger entries.
- It retires entries in program order, driving exactly one predictor/BTB update per retired branch. This serialises training so that updates only come from non-squashed, in-order branches.

Parameters:
- PC_WIDTH, 32, width of all PCs and targets.
- DEPTH, 8, number of queue entries; must be a power of 2.
- PTR_WIDTH, 3, log2(DEPTH); tag and pointer width.
- FLUSH_CYCLES, 2, cycles in which allocation is blocked after a flush; must be at least 1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- alloc_valid  input  1  fetch requests an entry for a predicted branch.
- alloc_ready  output  1  entry can be accepted this cycle.
- alloc_pc  input  PC_WIDTH  branch PC.
- alloc_pred_taken  input  1  predicted direction.
- alloc_pred_target  input  PC_WIDTH  predicted target (BTB).
- alloc_tag  output  PTR_WIDTH  tag assigned to the entry; equals the current tail pointer.
- resolve_valid  input  1  execute has resolved a branch.
- resolve_tag  input  PTR_WIDTH  tag of the resolved branch.
- resolve_taken  input  1  actual direction.
- resolve_target  input  PC_WIDTH  actual target.
- upd_valid  output  1  one-cycle pulse: train predictor/BTB.
- upd_pc  output  PC_WIDTH  retired branch PC.
- upd_taken  output  1  retired actual direction.
- upd_target  output  PC_WIDTH  retired actual target.
- flush  output  1  one-cycle pulse on mispredict.
- recover_pc  output  PC_WIDTH  redirect PC, valid when flush=1.
- count  output  PTR_WIDTH+1  number of occupied entries.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.

Behaviour:
- Storage: circular buffer with head and tail pointers of PTR_WIDTH bits, wrapping modulo DEPTH. Each entry holds {valid, resolved, pc, pred_taken, pred_target, act_taken, act_target}.
- Reset (reset=0, any time, including mid-flush): all entry valid bits cleared, head=tail=0, state=RUN, flush counter=0. All registered outputs are 0 (upd_*, flush, recover_pc). count=0, empty=1, full=0.
- FSM states:
  - RUN to BLOCK on a mispredict.
  - BLOCK holds for FLUSH_CYCLES cycles via a down-counter, then returns to RUN.
  - A new mispredict while in BLOCK reloads the counter.
- alloc_ready is combinational: (state==RUN) && !full && !mispredict_now.
- Allocation: when alloc_valid && alloc_ready, write the entry at tail with valid=1 and resolved=0, then tail+1. alloc_tag is shown combinationally.
- Resolution: when resolve_valid and entry[resolve_tag].valid && !resolved, set resolved, act_taken and act_target.
- Resolves to an invalid or already-resolved tag are ignored, with no flush and no state change.
- Resolves are still accepted during BLOCK.
- Mispredict condition: (resolve_taken != pred_taken) || (resolve_taken && resolve_target != pred_target).
- On a mispredict, with the effects registered and visible the next cycle:
  - flush=1 for exactly 1 cycle.
  - recover_pc = resolve_taken ? resolve_target : pc+4.
  - tail = resolve_tag+1.
  - Every entry strictly younger than resolve_tag (from resolve_tag+1 up to the old tail) is invalidated.
  - The mispredicted entry itself stays valid and is retired normally.
- Retire: when entry[head] is valid and resolved:
  - next cycle, upd_valid=1 and upd_pc/upd_taken/upd_target come from that entry;
  - valid is cleared and head+1.
  - At most 1 retire per cycle. Latency from resolve of the head to upd_valid is 1 cycle minimum.
- count = occupied entries after the update, registered. It is decremented by retire, incremented by alloc, and reduced by the number of squashed entries.
- Simultaneous events:
  - Alloc in the same cycle as a mispredict is refused (alloc_ready=0).
  - Retire of the head in the same cycle as a mispredict proceeds; the head is never younger than the resolved tag.
  - Retire and alloc in the same cycle while full: alloc is refused because full is evaluated on the pre-cycle count.
- Entries are never overwritten while valid.

Decomposition:
- Shared package brq_pkg contains:
  - the state enum {RUN, BLOCK};
  - the entry struct typedef;
  - the function is_younger(tag, ref, head) for modulo-DEPTH age compare;
  - the constant INSN_BYTES=4 for the fall-through PC.
- One sub-module: brq_flush_ctrl, holding the RUN/BLOCK FSM, the FLUSH_CYCLES counter and the flush/recover_pc registers.

Test Plan:
- Reset mid-operation: assert reset=0 while count=5 and in BLOCK → same cycle count=0, empty=1, flush=0, alloc_ready=1 after release.
- Fill and wrap:
  - 8 allocs with pc=0x100..0x11C, then full=1 and alloc_ready=0.
  - Resolve tag0 correctly (taken=0, pred=0) → upd_valid with upd_pc=0x100, next alloc gets tag0 after wrap.
- Out-of-order resolve: allocs at tags 0,1,2, correct resolves in order 2,1,0 → no upd until tag0 resolves, then upd_valid on 3 consecutive cycles with pc order 0,1,2.
- Direction mispredict: tags 0..3 allocated, tag1 pc=0x200 pred_taken=1, resolve tag1 taken=0 →
  - next cycle flush=1, recover_pc=0x204, count=2, tail=2;
  - alloc_ready=0 for 2 cycles;
  - later resolve of tag3 is ignored.
- Target mispredict: pred_taken=1 pred_target=0x400, resolve taken=1 target=0x480 → flush=1, recover_pc=0x480, retired upd_target=0x480.
- Simultaneous events: mispredict resolve in the same cycle as alloc_valid=1 and a head retire → alloc refused, upd_valid for the head next cycle, flush in that same cycle.
